arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Multi-cycle ARM control unit that sits directly upstream of the register file. It decodes the latched instruction fields and sequences each instruction through a Moore state machine. It drives the register-file write enable, the memory write enable, the PC and IR write enables, and the datapath mux selects. It also holds the NZCV condition flags and gates all architectural writes on the instruction's condition field.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- Cond  input  4  Instr[31:28], condition field
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S or L
- Rd  input  4  Instr[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  data memory write enable
- RegWrite  output  1  register-file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU result
- ALUSrcA  output  1  0=RD1, 1=PC
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  output  2  equal to Op
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01)
- Flags  output  4  registered {N,Z,C,V}
- State  output  4  current state encoding, for debug

## Operation
States and encodings:
- FETCH=0: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
- DECODE=1: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. CondExR is loaded here.
- MEMADR=2: ALUSrcA=0, ALUSrcB=01, ADD.
- MEMRD=3: AdrSrc=1, ResultSrc=00.
- MEMWB=4: ResultSrc=01, RegW=1.
- MEMWR=5: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER=6: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI=7: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB=8: ResultSrc=00, RegW=1.
- BRANCH=9: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch=1.
- Unlisted select outputs are 0 in every state.

Transitions:
- FETCH always goes to DECODE.
- DECODE branches on Op: 00 goes to EXECUTEI if Funct[5]=1, otherwise EXECUTER; 01 goes to MEMADR; 10 goes to BRANCH; 11 goes to FETCH (undefined instruction, no writes).
- MEMADR goes to MEMRD if Funct[0]=1, otherwise MEMWR.
- MEMRD goes to MEMWB, which goes to FETCH. MEMWR goes to FETCH.
- EXECUTER and EXECUTEI go to ALUWB, which goes to FETCH. BRANCH goes to FETCH.
- Encodings 10–15 go to FETCH.

ALU decode (applies only when ALUOp=1, otherwise ALUControl=ADD):
- cmd 0100 gives ADD, 0010 SUB, 0000 AND, 1100 ORR.
- Any other cmd gives ADD with FlagW=00.
- FlagW[1] (N,Z) = S. FlagW[0] (C,V) = S & arithmetic (ADD or SUB).

Condition unit:
- CondEx is evaluated from the registered Flags for the 15 ARM conditions EQ…AL.
- Cond=1111 gives CondEx=0.
- CondExR is a register loaded with CondEx on the clock edge leaving DECODE. Every later state uses CondExR, so a flag update in EXECUTE cannot change the gating of ALUWB.

Write gating:
- PCS = Branch | (RegW & Rd==15).
- PCWrite = NextPC | (PCS & CondExR).
- RegWrite = RegW & CondExR & ~NoWrite.
- MemWrite = MemW & CondExR.

Flags update:
- Flags[3:2] load ALUFlags[3:2] on the edge leaving EXECUTER/EXECUTEI when FlagW[1] & CondExR.
- Flags[1:0] load under the same rule with FlagW[0].

## Timing
- Reset asserted (asynchronous): State=FETCH, Flags=0000, CondExR=0.
- While Reset is low, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. All other outputs take their FETCH values.
- After Reset is released, the first rising edge performs the FETCH writes.
- Outputs are combinational from State, the instruction fields and CondExR. There are no registered outputs other than Flags and State.
- Instruction latency: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- Reset asserted mid-instruction aborts immediately. No partial write completes after Reset falls.

## Configuration
- ARM_MC_CMP_EN
  - Defined: cmd 1010 (CMP) decodes as SUB with FlagW=S?11:00 and NoWrite=1, so ALUWB updates flags but RegWrite stays 0.
  - Undefined: cmd 1010 is treated as unsupported (ADD, FlagW=00, NoWrite=0).
  - NoWrite is constant 0 in every other case.

## Test plan
- Reset low for 2 cycles with Op=00 applied → State=0, Flags=0000, all four write enables 0. After release, the first cycle shows IRWrite=1 and PCWrite=1.
- ADD R1,R2,R3 with Cond=1110, Funct=001000 → states 0,1,6,8,0. ALUControl=00 in state 6. RegWrite=1 only in state 8.
- SUBS with Cond=1110, Funct=000101 and ALUFlags=0100 during EXECUTER → Flags=0100 after state 6. A following BEQ (Cond=0000, Op=10) asserts PCWrite in BRANCH.
- LDR (Op=01, Funct[0]=1) takes 5 cycles with RegWrite in state 4 and ResultSrc=01. STR (Funct[0]=0) asserts MemWrite=1 only in state 5, with AdrSrc=1.
- ADDNE with Z=1 → RegWrite stays 0 in ALUWB. An ADDEQS that sets Z=0 in EXECUTE still writes in ALUWB, because gating uses CondExR.
- CMP (cmd 1010, S=1):
  - With ARM_MC_CMP_EN defined: ALUControl=01, flags update, RegWrite=0.
  - Without it: ALUControl=00, flags unchanged.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multi-cycle ARM control unit: Moore sequencer, ALU decode, NZCV flags and condition gating.
// Optional CMP support is enabled by defining ARM_MC_CMP_EN.
module arm_mc_controller (
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
    logic       cond_ex, pcs, no_write;
    logic [1:0] dec_ctl, dec_flag_w, flag_w;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd:    state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Moore control decode; anything not set here stays 0.
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state_q)
            StFetch: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc  = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            StExecuteR: alu_op = 1'b1;
            StExecuteI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            StAluWb: reg_w = 1'b1;
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // NoWrite is decoded regardless of ALUOp because it must still hold in ALUWB.
    always_comb begin
        dec_ctl    = 2'b00;
        dec_flag_w = 2'b00;
        no_write   = 1'b0;
        case (Funct[4:1])
            4'b0100: begin dec_ctl = 2'b00; dec_flag_w = {Funct[0], Funct[0]}; end
            4'b0010: begin dec_ctl = 2'b01; dec_flag_w = {Funct[0], Funct[0]}; end
            4'b0000: begin dec_ctl = 2'b10; dec_flag_w = {Funct[0], 1'b0};     end
            4'b1100: begin dec_ctl = 2'b11; dec_flag_w = {Funct[0], 1'b0};     end
`ifdef ARM_MC_CMP_EN
            4'b1010: begin
                dec_ctl    = 2'b01;
                dec_flag_w = {Funct[0], Funct[0]};
                no_write   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ALUControl = alu_op ? dec_ctl : 2'b00;
    assign flag_w     = alu_op ? dec_flag_w : 2'b00;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign cond_ex_d = (state_q == StDecode) ? cond_ex : cond_ex_q;

    always_comb begin
        flags_d = flags_q;
        if (((state_q == StExecuteR) || (state_q == StExecuteI)) && cond_ex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Reset gates the write enables so nothing commits while it is held low.
    assign pcs      = branch | (reg_w & (Rd == 4'd15));
    assign PCWrite  = Reset & (next_pc | (pcs & cond_ex_q));
    assign RegWrite = Reset & reg_w & cond_ex_q & ~no_write;
    assign MemWrite = Reset & mem_w & cond_ex_q;
    assign IRWrite  = Reset & ir_w;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags  = flags_q;
    assign State  = state_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: stimulus queues per-cycle expectations, a monitor
// compares them on the falling edge. Honours ARM_MC_CMP_EN for the CMP expectations.
module tb_arm_mc_controller;

    logic       clk;
    logic       Reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags, State;

    arm_mc_controller dut (
        .clk       (clk),
        .Reset     (Reset),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .Flags     (Flags),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] we;    // {PCWrite, MemWrite, RegWrite, IRWrite}
        logic [5:0] sel;   // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
        logic [1:0] aluc;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic [3:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [3:0] ef;

    // Per-state mux selects taken from the state table.
    function automatic logic [5:0] sel_of(input logic [3:0] st);
        case (st)
            4'd0, 4'd1: sel_of = 6'b0_10_1_10;
            4'd2:       sel_of = 6'b0_00_0_01;
            4'd3, 4'd5: sel_of = 6'b1_00_0_00;
            4'd4:       sel_of = 6'b0_01_0_00;
            4'd7:       sel_of = 6'b0_00_0_01;
            4'd9:       sel_of = 6'b0_10_0_01;
            default:    sel_of = 6'b0_00_0_00;
        endcase
    endfunction

    task automatic step(input logic [3:0] st, input logic [3:0] we, input logic [1:0] aluc,
                        input logic [3:0] fl);
        exp_t e;
        e.st   = st;
        e.we   = we;
        e.sel  = sel_of(st);
        e.aluc = aluc;
        e.imm  = Op;
        e.rsrc = {(Op == 2'b01), (Op == 2'b10)};
        e.fl   = fl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r);
        Cond  = c;
        Op    = o;
        Funct = f;
        Rd    = r;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [11:0] mux_act, mux_exp;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            mux_act = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
            mux_exp = {e.sel, e.aluc, e.imm, e.rsrc};
            n_checks++;
            if (State !== e.st) begin
                n_fail++;
                $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, State, e.st);
            end
            n_checks++;
            if ({PCWrite, MemWrite, RegWrite, IRWrite} !== e.we) begin
                n_fail++;
                $display("FAIL write_en cyc=%0d got=%b want=%b", cyc,
                         {PCWrite, MemWrite, RegWrite, IRWrite}, e.we);
            end
            n_checks++;
            if (mux_act !== mux_exp) begin
                n_fail++;
                $display("FAIL selects cyc=%0d got=%b want=%b", cyc, mux_act, mux_exp);
            end
            n_checks++;
            if (Flags !== e.fl) begin
                n_fail++;
                $display("FAIL flags cyc=%0d got=%b want=%b", cyc, Flags, e.fl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset    = 1'b0;
        ALUFlags = 4'b0000;
        instr(4'b1110, 2'b00, 6'b001000, 4'd1);
        ef = 4'b0000;
        @(posedge clk);
        #1;
        // Reset held for two cycles
        step(4'd0, 4'b0000, 2'b00, ef);
        step(4'd0, 4'b0000, 2'b00, ef);
        Reset = 1'b1;

        // ADD R1,R2,R3
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b0010, 2'b00, ef);

        // SUBS, ALU reports Z
        instr(4'b1110, 2'b00, 6'b000101, 4'd2);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b0100;
        step(4'd6, 4'b0000, 2'b01, ef);
        ALUFlags = 4'b0000;
        ef = 4'b0100;
        step(4'd8, 4'b0010, 2'b00, ef);

        // BEQ taken
        instr(4'b0000, 2'b10, 6'b000000, 4'd0);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd9, 4'b1000, 2'b00, ef);

        // LDR
        instr(4'b1110, 2'b01, 6'b011001, 4'd3);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd2, 4'b0000, 2'b00, ef);
        step(4'd3, 4'b0000, 2'b00, ef);
        step(4'd4, 4'b0010, 2'b00, ef);

        // STR
        instr(4'b1110, 2'b01, 6'b011000, 4'd3);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd2, 4'b0000, 2'b00, ef);
        step(4'd5, 4'b0100, 2'b00, ef);

        // ADDNE with Z=1: suppressed
        instr(4'b0001, 2'b00, 6'b001000, 4'd4);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b0000, 2'b00, ef);

        // ADDEQS clears Z in EXECUTE but still writes back
        instr(4'b0000, 2'b00, 6'b001001, 4'd5);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b0010;
        step(4'd6, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b0000;
        ef = 4'b0010;
        step(4'd8, 4'b0010, 2'b00, ef);

        // ADD immediate
        instr(4'b1110, 2'b00, 6'b101000, 4'd6);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd7, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b0010, 2'b00, ef);

        // ANDS immediate: only N,Z load
        instr(4'b1110, 2'b00, 6'b100001, 4'd6);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b1111;
        step(4'd7, 4'b0000, 2'b10, ef);
        ALUFlags = 4'b0000;
        ef = 4'b1110;
        step(4'd8, 4'b0010, 2'b00, ef);

        // ORR register
        instr(4'b1110, 2'b00, 6'b011000, 4'd7);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b11, ef);
        step(4'd8, 4'b0010, 2'b00, ef);

        // Unsupported cmd 0001 with S=1: ADD, no flag update
        instr(4'b1110, 2'b00, 6'b000011, 4'd7);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b0010, 2'b00, ef);

        // CMP
        instr(4'b1110, 2'b00, 6'b010101, 4'd8);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b0100;
`ifdef ARM_MC_CMP_EN
        step(4'd6, 4'b0000, 2'b01, ef);
        ALUFlags = 4'b0000;
        ef = 4'b0100;
        step(4'd8, 4'b0000, 2'b00, ef);
`else
        step(4'd6, 4'b0000, 2'b00, ef);
        ALUFlags = 4'b0000;
        step(4'd8, 4'b0010, 2'b00, ef);
`endif

        // Undefined Op=11
        instr(4'b1110, 2'b11, 6'b000000, 4'd0);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);

        // ADD to R15 writes the PC in ALUWB
        instr(4'b1110, 2'b00, 6'b001000, 4'd15);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b1010, 2'b00, ef);

        // BNE with Z=1: not taken
        instr(4'b0001, 2'b10, 6'b000000, 4'd0);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd9, 4'b0000, 2'b00, ef);

        // Cond=1111 never executes
        instr(4'b1111, 2'b00, 6'b001000, 4'd1);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        step(4'd6, 4'b0000, 2'b00, ef);
        step(4'd8, 4'b0000, 2'b00, ef);

        // Reset in the middle of an ADDS aborts it
        instr(4'b1110, 2'b00, 6'b001001, 4'd1);
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);
        Reset    = 1'b0;
        ALUFlags = 4'b1111;
        ef       = 4'b0000;
        step(4'd0, 4'b0000, 2'b00, ef);
        step(4'd0, 4'b0000, 2'b00, ef);
        Reset    = 1'b1;
        ALUFlags = 4'b0000;
        step(4'd0, 4'b1001, 2'b00, ef);
        step(4'd1, 4'b0000, 2'b00, ef);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
